// File: rtl/fc_layer_sequencer.sv
// ---------------------------------------------------------------------------
// fc_layer_sequencer
//
// Top-level scheduler for the two fully-connected stages of the accelerator:
// FC1 (FC1_NODES nodes, FC1_BATCHES 32-element beats per node) and FC2
// (FC2_NODES nodes, one beat each). One run does the following, in order:
//   1. Clears the FC accumulators.
//   2. Streams the FC1 weight and data read addresses.
//   3. Streams the FC2 weight addresses.
//   4. Optionally picks the winning class from the FC2 outputs.
// The enables are the issue strobes delayed by the BRAM read latency, so each
// enable lines up with the data it qualifies.
//
// Build option:
//   FC_ARGMAX_EN  defined   -> ARGMAX state built; class_id/class_valid driven.
//                 undefined -> FC2_DRAIN goes straight to FIN; class_id and
//                              class_valid are tied to 0; fc2_out is unused.
//
// Handshake: start is a request sampled only in IDLE. A start in any other
// state is dropped, not queued. busy is high from the cycle after the accept
// through the FIN cycle. done is a one-cycle pulse in FIN. There is no
// back-pressure: once an address issues, its enable always follows.
//
// Ports:
//   clk, rst_n    clock; synchronous active-low reset
//   start         run request
//   busy, done    run status and end-of-run pulse
//   layer         0 = idle/clear, 1 = FC1, 2 = FC2, 3 = argmax
//   fc1_en        FC1 datapath enable
//   fc1_waddr     FC1 weight address (node*FC1_BATCHES + batch)
//   fc1_daddr     FC1 data address (batch)
//   fc2_en        FC2 datapath enable
//   fc2_waddr     FC2 weight address (node)
//   fc2_out       FC2 signed outputs; class j sits at [DW*j +: DW]
//   class_id      winning class
//   class_valid   class_id valid
//   state_dbg     current FSM state, for debug and checkers
// ---------------------------------------------------------------------------
module fc_layer_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int FC1_BATCHES = 32,
  parameter int FC1_NODES   = 64,
  parameter int FC2_NODES   = 10,
  parameter int RD_LAT      = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic [3:0]                      layer,
  output logic                            fc1_en,
  output logic [10:0]                     fc1_waddr,
  output logic [4:0]                      fc1_daddr,
  output logic                            fc2_en,
  output logic [3:0]                      fc2_waddr,
  input  logic [FC2_NODES*DATA_WIDTH-1:0] fc2_out,
  output logic [3:0]                      class_id,
  output logic                            class_valid,
  output logic [2:0]                      state_dbg
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CLR       = 3'd1;
  localparam logic [2:0] S_FC1_ISSUE = 3'd2;
  localparam logic [2:0] S_FC1_DRAIN = 3'd3;
  localparam logic [2:0] S_FC2_ISSUE = 3'd4;
  localparam logic [2:0] S_FC2_DRAIN = 3'd5;
`ifdef FC_ARGMAX_EN
  localparam logic [2:0] S_ARGMAX    = 3'd6;
`endif
  localparam logic [2:0] S_FIN       = 3'd7;

  logic [2:0] state;
  logic [4:0] batch_cnt;
  logic [5:0] node_cnt;
  // Shared counter for the drain, FC2-issue and argmax phases.
  logic [3:0] ph_cnt;

  logic fc1_issue;
  logic fc2_issue;
  logic batch_last;
  logic fc1_last;
  logic drain_last;
  logic fc2_last;

  logic [RD_LAT-1:0] fc1_pipe;
  logic [RD_LAT-1:0] fc2_pipe;

  assign fc1_issue  = (state == S_FC1_ISSUE);
  assign fc2_issue  = (state == S_FC2_ISSUE);
  assign batch_last = (batch_cnt == 5'(FC1_BATCHES - 1));
  assign fc1_last   = batch_last && (node_cnt == 6'(FC1_NODES - 1));
  // A drain lasts RD_LAT+2 cycles: the read latency plus the datapath's
  // one-cycle node-delay accumulate.
  assign drain_last = (ph_cnt == 4'(RD_LAT + 1));
  assign fc2_last   = (ph_cnt == 4'(FC2_NODES - 1));

  // FSM and address counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      batch_cnt <= '0;
      node_cnt  <= '0;
      ph_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state <= S_CLR;
        end
        S_CLR: begin
          batch_cnt <= '0;
          node_cnt  <= '0;
          ph_cnt    <= '0;
          state     <= S_FC1_ISSUE;
        end
        S_FC1_ISSUE: begin
          if (fc1_last) begin
            batch_cnt <= '0;
            node_cnt  <= '0;
            ph_cnt    <= '0;
            state     <= S_FC1_DRAIN;
          end else if (batch_last) begin
            batch_cnt <= '0;
            node_cnt  <= node_cnt + 6'd1;
          end else begin
            batch_cnt <= batch_cnt + 5'd1;
          end
        end
        S_FC1_DRAIN: begin
          if (drain_last) begin
            ph_cnt <= '0;
            state  <= S_FC2_ISSUE;
          end else begin
            ph_cnt <= ph_cnt + 4'd1;
          end
        end
        S_FC2_ISSUE: begin
          if (fc2_last) begin
            ph_cnt <= '0;
            state  <= S_FC2_DRAIN;
          end else begin
            ph_cnt <= ph_cnt + 4'd1;
          end
        end
        S_FC2_DRAIN: begin
          if (drain_last) begin
            ph_cnt <= '0;
`ifdef FC_ARGMAX_EN
            state  <= S_ARGMAX;
`else
            state  <= S_FIN;
`endif
          end else begin
            ph_cnt <= ph_cnt + 4'd1;
          end
        end
`ifdef FC_ARGMAX_EN
        S_ARGMAX: begin
          if (fc2_last) begin
            ph_cnt <= '0;
            state  <= S_FIN;
          end else begin
            ph_cnt <= ph_cnt + 4'd1;
          end
        end
`endif
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // The enables are the issue strobes delayed by the BRAM read latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fc1_pipe <= '0;
      fc2_pipe <= '0;
    end else begin
      fc1_pipe <= RD_LAT'({fc1_pipe, fc1_issue});
      fc2_pipe <= RD_LAT'({fc2_pipe, fc2_issue});
    end
  end

  assign fc1_en = fc1_pipe[RD_LAT-1];
  assign fc2_en = fc2_pipe[RD_LAT-1];

  // Addresses read 0 outside their issue window.
  always_comb begin
    fc1_waddr = '0;
    fc1_daddr = '0;
    fc2_waddr = '0;
    if (fc1_issue) begin
      fc1_waddr = 11'(node_cnt) * 11'(FC1_BATCHES) + 11'(batch_cnt);
      fc1_daddr = batch_cnt;
    end
    if (fc2_issue) begin
      fc2_waddr = ph_cnt;
    end
  end

  // Each phase code holds through its matching drain state.
  always_comb begin
    layer = 4'd0;
    case (state)
      S_FC1_ISSUE, S_FC1_DRAIN: layer = 4'd1;
      S_FC2_ISSUE, S_FC2_DRAIN: layer = 4'd2;
`ifdef FC_ARGMAX_EN
      S_ARGMAX:                 layer = 4'd3;
`endif
      default:                  layer = 4'd0;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_FIN);
  assign state_dbg = state;

`ifdef FC_ARGMAX_EN
  // Scan one class per cycle. A strict signed '>' keeps the lowest index on
  // a tie. On the last scan cycle the winner is registered directly, so
  // class_valid rises together with done.
  logic signed [DATA_WIDTH-1:0] cur_val;
  logic signed [DATA_WIDTH-1:0] best_val;
  logic [3:0]                   best_idx;
  logic                         take;

  assign cur_val = fc2_out[int'(ph_cnt)*DATA_WIDTH +: DATA_WIDTH];
  assign take    = (ph_cnt == 4'd0) || (cur_val > best_val);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      best_val    <= '0;
      best_idx    <= '0;
      class_id    <= '0;
      class_valid <= 1'b0;
    end else if (state == S_CLR) begin
      class_id    <= '0;
      class_valid <= 1'b0;
    end else if (state == S_ARGMAX) begin
      if (take) begin
        best_val <= cur_val;
        best_idx <= ph_cnt;
      end
      if (fc2_last) begin
        class_id    <= take ? ph_cnt : best_idx;
        class_valid <= 1'b1;
      end
    end
  end
`else
  logic unused_fc2;
  assign unused_fc2  = ^fc2_out;
  assign class_id    = 4'd0;
  assign class_valid = 1'b0;
`endif

endmodule

// File: tb/tb_fc_layer_sequencer.sv
`timescale 1ns/1ps
module tb_fc_layer_sequencer;

  localparam int RD_LAT      = 1;
  localparam int FC1_TOTAL   = 2048;
  // Cycle numbers count negedges after the accept edge. Cycle 1 is CLR.
  localparam int C_FC1       = 2;
  localparam int C_FC1_DRAIN = C_FC1 + FC1_TOTAL;         // 2050
  localparam int C_FC2       = C_FC1_DRAIN + RD_LAT + 2;  // 2053
  localparam int C_FC2_DRAIN = C_FC2 + 10;                // 2063
  localparam int C_AFTER     = C_FC2_DRAIN + RD_LAT + 2;  // 2066
`ifdef FC_ARGMAX_EN
  localparam int LAT         = C_AFTER + 10;              // 2076: FIN cycle
`else
  localparam int LAT         = C_AFTER;                   // 2066: FIN cycle
`endif

  // Clock and reset
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done, fc1_en, fc2_en, class_valid;
  logic [3:0]  layer, fc2_waddr, class_id;
  logic [10:0] fc1_waddr;
  logic [4:0]  fc1_daddr;
  logic [79:0] fc2_out;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fc_layer_sequencer #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .layer(layer), .fc1_en(fc1_en), .fc1_waddr(fc1_waddr), .fc1_daddr(fc1_daddr),
    .fc2_en(fc2_en), .fc2_waddr(fc2_waddr), .fc2_out(fc2_out),
    .class_id(class_id), .class_valid(class_valid), .state_dbg(state_dbg)
  );

  function automatic logic [3:0] exp_layer(input int c);
    if (c >= C_FC1 && c < C_FC2) return 4'd1;
    if (c >= C_FC2 && c < C_AFTER) return 4'd2;
    if (c >= C_AFTER && c < LAT) return 4'd3;
    return 4'd0;
  endfunction

  // Driver and per-run scoreboard. A start pulse is issued, then every cycle
  // is sampled on the negedge. poke_cyc > 0 raises start again during that
  // cycle. abort_cyc > 0 asserts reset during that cycle.
  task automatic run_seq(input string name, input int poke_cyc, input int abort_cyc,
                         input logic [3:0] exp_cls);
    int fc1_hi = 0, fc1_rise = 0, fc1_first = -1;
    int fc2_hi = 0, fc2_rise = 0, fc2_first = -1;
    int done_n = 0, done_at = -1, addr_bad = 0, bad_cyc = -1, layer_bad = 0, busy_bad = 0;
    int exp_w, exp_w2;
    logic p1 = 1'b0, p2 = 1'b0;
    logic [3:0] cls_at_done = 4'hx;
    logic cv_at_done = 1'bx;
    logic [3:0] want_cls;
    logic want_cv;
`ifdef FC_ARGMAX_EN
    want_cls = exp_cls;
    want_cv  = 1'b1;
`else
    want_cls = 4'd0;
    want_cv  = 1'b0;
`endif
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc <= LAT + 4; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (abort_cyc > 0 && cyc == abort_cyc + 1) begin
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || layer !== 4'd0 || fc1_en !== 1'b0 ||
            fc2_en !== 1'b0 || fc1_waddr !== 11'd0 || fc1_daddr !== 5'd0 ||
            fc2_waddr !== 4'd0 || class_id !== 4'd0 || class_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s abort_outputs: got busy=%b done=%b layer=%0d en=%b%b wa=%0d da=%0d w2=%0d cls=%0d cv=%b expected all 0",
                   name, busy, done, layer, fc1_en, fc2_en, fc1_waddr, fc1_daddr, fc2_waddr, class_id, class_valid);
        end
        checks++;
        if (done_n !== 0) begin
          errors++;
          $display("FAIL %s abort_no_done: got %0d done pulses expected 0", name, done_n);
        end
        rst_n = 1'b1;
        return;
      end
      start = (cyc == poke_cyc);
      if (abort_cyc > 0 && cyc == abort_cyc) rst_n = 1'b0;

      if (fc1_en === 1'b1) begin
        fc1_hi++;
        if (!p1) begin fc1_rise++; if (fc1_first < 0) fc1_first = cyc; end
      end
      p1 = (fc1_en === 1'b1);
      if (fc2_en === 1'b1) begin
        fc2_hi++;
        if (!p2) begin fc2_rise++; if (fc2_first < 0) fc2_first = cyc; end
      end
      p2 = (fc2_en === 1'b1);

      exp_w  = (cyc >= C_FC1 && cyc < C_FC1_DRAIN) ? cyc - C_FC1 : 0;
      exp_w2 = (cyc >= C_FC2 && cyc < C_FC2_DRAIN) ? cyc - C_FC2 : 0;
      if (fc1_waddr !== 11'(exp_w) || fc1_daddr !== 5'(exp_w % 32) || fc2_waddr !== 4'(exp_w2)) begin
        if (addr_bad == 0) bad_cyc = cyc;
        addr_bad++;
      end
      if (cyc == C_FC1 + 32) begin
        checks++;
        if (fc1_waddr !== 11'd32 || fc1_daddr !== 5'd0) begin
          errors++;
          $display("FAIL %s fc1_batch_wrap: got waddr=%0d daddr=%0d expected waddr=32 daddr=0", name, fc1_waddr, fc1_daddr);
        end
      end
      if (layer !== exp_layer(cyc)) layer_bad++;
      if (busy !== (cyc <= LAT)) busy_bad++;
      if (done === 1'b1) begin
        done_n++;
        done_at     = cyc;
        cls_at_done = class_id;
        cv_at_done  = class_valid;
      end
    end
    start = 1'b0;

    checks++;
    if (fc1_hi != FC1_TOTAL || fc1_rise != 1) begin
      errors++;
      $display("FAIL %s fc1_en_window: got %0d cycles in %0d bursts expected %0d in 1", name, fc1_hi, fc1_rise, FC1_TOTAL);
    end
    checks++;
    if (fc1_first != C_FC1 + RD_LAT) begin
      errors++;
      $display("FAIL %s fc1_en_first: got cycle %0d expected %0d", name, fc1_first, C_FC1 + RD_LAT);
    end
    checks++;
    if (fc2_hi != 10 || fc2_rise != 1 || fc2_first != C_FC2 + RD_LAT) begin
      errors++;
      $display("FAIL %s fc2_en_window: got %0d cycles %0d bursts first %0d expected 10 1 %0d",
               name, fc2_hi, fc2_rise, fc2_first, C_FC2 + RD_LAT);
    end
    checks++;
    if (addr_bad != 0) begin
      errors++;
      $display("FAIL %s addr_sequence: got %0d bad cycles (first at %0d) expected 0", name, addr_bad, bad_cyc);
    end
    checks++;
    if (layer_bad != 0) begin
      errors++;
      $display("FAIL %s layer_sequence: got %0d bad cycles expected 0", name, layer_bad);
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL %s busy_window: got %0d bad cycles expected 0", name, busy_bad);
    end
    checks++;
    if (done_n != 1 || done_at != LAT) begin
      errors++;
      $display("FAIL %s done_latency: got %0d pulses last at cycle %0d expected 1 at %0d", name, done_n, done_at, LAT);
    end
    checks++;
    if (cls_at_done !== want_cls || cv_at_done !== want_cv) begin
      errors++;
      $display("FAIL %s class_at_done: got id=%0d valid=%b expected id=%0d valid=%b",
               name, cls_at_done, cv_at_done, want_cls, want_cv);
    end
    checks++;
    if (class_valid !== want_cv || class_id !== want_cls) begin
      errors++;
      $display("FAIL %s class_hold: got id=%0d valid=%b expected id=%0d valid=%b",
               name, class_id, class_valid, want_cls, want_cv);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || fc1_en !== 1'b0 || fc2_en !== 1'b0 ||
          layer !== 4'd0 || class_valid !== 1'b0 || class_id !== 4'd0) begin
        errors++;
        $display("FAIL reset_hold: got busy=%b done=%b en=%b%b layer=%0d cv=%b cls=%0d expected all 0",
                 busy, done, fc1_en, fc2_en, layer, class_valid, class_id);
      end
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || fc1_waddr !== 11'd0 || fc2_waddr !== 4'd0) begin
      errors++;
      $display("FAIL reset_release_idle: got busy=%b wa=%0d w2=%0d expected 0 0 0", busy, fc1_waddr, fc2_waddr);
    end
  endtask

  // Class 3 ties class 7 at 0x40; 0x80 at class 0 only wins if the compare
  // is unsigned.
  task automatic test_full_run();
    fc2_out = {8'hC0, 8'h01, 8'h40, 8'h00, 8'h20, 8'hF0, 8'h40, 8'h3F, 8'h10, 8'h80};
    run_seq("full_run", 0, 0, 4'd3);
  endtask

  task automatic test_start_during_busy();
    fc2_out = {10{8'hF0}};
    run_seq("busy_start", 500, 0, 4'd0);
  endtask

  // The last class is the unique maximum, so the final scan cycle counts.
  task automatic test_start_at_done();
    fc2_out = {8'h7F, {9{8'h40}}};
    run_seq("start_at_done", LAT, 0, 4'd9);
  endtask

  task automatic test_reset_mid_run();
    fc2_out = {8'hC0, 8'h01, 8'h40, 8'h00, 8'h20, 8'hF0, 8'h40, 8'h3F, 8'h10, 8'h80};
    run_seq("abort", 0, 1000, 4'd3);
    run_seq("after_abort", 0, 0, 4'd3);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    fc2_out = '0;
    test_reset();
    test_full_run();
    test_start_during_busy();
    test_start_at_done();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
